// File: rtl/cache_types.sv
// Shared types and geometry for the direct-mapped cache responder.
package cache_types;

  localparam int unsigned S_INDEX    = 3;
  localparam int unsigned S_OFFSET   = 5;
  localparam int unsigned S_TAG      = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned NUM_SETS   = 1 << S_INDEX;
  localparam int unsigned LINE_BYTES = 1 << S_OFFSET;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  typedef logic [255:0] line_t;

endpackage

// File: rtl/dm_cache_array.sv
// Flop-based tag/valid/dirty/data storage: combinational read, byte-masked synchronous write.
module dm_cache_array
  import cache_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] i_index,
  output logic [S_TAG-1:0]   o_tag,
  output logic               o_valid,
  output logic               o_dirty,
  output line_t              o_line,
  input  logic [31:0]        i_byte_we,
  input  line_t              i_wdata,
  input  logic               i_tag_we,
  input  logic [S_TAG-1:0]   i_tag,
  input  logic               i_valid_set,
  input  logic               i_dirty_set,
  input  logic               i_dirty_clr
);

  logic [S_TAG-1:0]    r_tag  [NUM_SETS];
  line_t               r_data [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;

  assign o_tag   = r_tag[i_index];
  assign o_line  = r_data[i_index];
  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];

  // Status bits: cleared by reset, set/cleared by the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_valid_set) r_valid[i_index] <= 1'b1;
      if (i_dirty_clr) r_dirty[i_index] <= 1'b0;
      if (i_dirty_set) r_dirty[i_index] <= 1'b1;
    end
  end

  // Tag and data are never cleared; writes are only suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (i_byte_we[b]) r_data[i_index][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      if (i_tag_we) r_tag[i_index] <= i_tag;
    end
  end

endmodule

// File: rtl/dm_cache_responder.sv
// Direct-mapped write-back/write-allocate cache: FSM, hit compare, word select, byte merge.
module dm_cache_responder
  import cache_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [255:0] pmem_rdata
);

  state_t r_state, w_state_next;

  logic [S_TAG-1:0]   w_addr_tag;
  logic [S_INDEX-1:0] w_index;
  logic [2:0]         w_word;
  logic               w_unused;

  logic [S_TAG-1:0] w_tag;
  logic             w_valid;
  logic             w_dirty;
  line_t            w_line;
  logic             w_hit;

  logic [31:0] w_byte_we;
  line_t       w_wdata;
  logic        w_tag_we;
  logic        w_valid_set;
  logic        w_dirty_set;
  logic        w_dirty_clr;

  assign w_addr_tag = mem_address[31 -: S_TAG];
  assign w_index    = mem_address[S_OFFSET +: S_INDEX];
  assign w_word     = mem_address[S_OFFSET-1:2];
  assign w_unused   = ^mem_address[1:0];
  assign w_hit      = w_valid && (w_tag == w_addr_tag);

  dm_cache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_index),
    .o_tag       (w_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_line      (w_line),
    .i_byte_we   (w_byte_we),
    .i_wdata     (w_wdata),
    .i_tag_we    (w_tag_we),
    .i_tag       (w_addr_tag),
    .i_valid_set (w_valid_set),
    .i_dirty_set (w_dirty_set),
    .i_dirty_clr (w_dirty_clr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state, CPU/memory strobes and array write controls.
  always_comb begin
    w_state_next = r_state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_byte_we    = '0;
    w_wdata      = '0;
    w_tag_we     = 1'b0;
    w_valid_set  = 1'b0;
    w_dirty_set  = 1'b0;
    w_dirty_clr  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_read || mem_write) w_state_next = CHECK;
      end
      CHECK: begin
        if (mem_read || mem_write) begin
          if (w_hit) begin
            mem_resp     = 1'b1;
            w_state_next = IDLE;
            // Write wins when both strobes are (illegally) high.
            if (mem_write) begin
              w_byte_we   = {28'b0, mem_byte_enable} << {w_word, 2'b00};
              w_wdata     = {8{mem_wdata}};
              w_dirty_set = 1'b1;
            end else begin
              mem_rdata = w_line[{w_word, 5'b0} +: 32];
            end
          end else if (w_valid && w_dirty) begin
            w_state_next = WRITEBACK;
          end else begin
            w_state_next = ALLOCATE;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = w_line;
        if (pmem_resp) begin
          w_dirty_clr  = 1'b1;
          w_state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          w_byte_we    = '1;
          w_wdata      = pmem_rdata;
          w_tag_we     = 1'b1;
          w_valid_set  = 1'b1;
          w_dirty_clr  = 1'b1;
          w_state_next = CHECK;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_responder.sv
// Directed self-checking bench for dm_cache_responder with a fixed-latency line memory model.
module tb_dm_cache_responder;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem [logic [31:0]];
  bit           ev_write [$];
  logic [31:0]  ev_addr  [$];
  logic [255:0] ev_wdata [$];
  int           resp_count = 0;
  int           overlap = 0;
  int           unstable = 0;

  dm_cache_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata)
  );

  always #5 clk = ~clk;

  // Line memory: acts on the falling edge, answers after LAT cycles of a held strobe.
  initial begin
    int cnt;
    logic         prev_rd, prev_wr;
    logic [31:0]  prev_addr;
    logic [255:0] prev_wd;
    cnt = 0; prev_rd = 0; prev_wr = 0; prev_addr = 0; prev_wd = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (mem_resp === 1'b1) resp_count++;
      if (pmem_read && pmem_write) overlap++;
      if ((pmem_read && prev_rd && pmem_address != prev_addr) ||
          (pmem_write && prev_wr && (pmem_address != prev_addr || pmem_wdata != prev_wd)))
        unstable++;
      prev_rd = pmem_read; prev_wr = pmem_write;
      prev_addr = pmem_address; prev_wd = pmem_wdata;
      if (rst) begin
        cnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (cnt == 0) begin
          ev_write.push_back(pmem_write);
          ev_addr.push_back(pmem_address);
          ev_wdata.push_back(pmem_wdata);
        end
        cnt++;
        if (cnt == LAT) begin
          pmem_resp = 1'b1;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : '0;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w1);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base | i;
    l[63:32] = w1;
    return l;
  endfunction

  function automatic void clear_events();
    ev_write.delete(); ev_addr.delete(); ev_wdata.delete();
  endfunction

  // Drives one request from posedge+1 and waits for the response; cyc=-1 on timeout.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    mem_write = we; mem_read = !we;
    cyc = 1; rd = 'x;
    while (mem_resp !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (mem_resp === 1'b1) rd = mem_rdata;
    else cyc = -1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {mem_resp, pmem_read, pmem_write});
    end
    checks++;
    if (mem_rdata !== 32'h0 || pmem_address !== 32'h0) begin
      errors++; $display("FAIL reset_data got rdata=%h paddr=%h want 0", mem_rdata, pmem_address);
    end
    checks++;
    if (pmem_wdata !== 256'h0) begin
      errors++; $display("FAIL reset_pwdata got %h want 0", pmem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read();
    logic [31:0] rd; int cyc; int r0;
    clear_events(); r0 = resp_count;
    do_req(1'b0, 32'h0000_1024, 4'h0, 32'h0, rd, cyc);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL cold_rdata got %h want deadbeef", rd);
    end
    checks++;
    if (cyc != 2 + LAT + 1) begin
      errors++; $display("FAIL cold_latency got %0d want %0d", cyc, 2 + LAT + 1);
    end
    checks++;
    if (ev_addr.size() != 1 || ev_write[0] !== 1'b0 || ev_addr[0] !== 32'h0000_1020) begin
      errors++; $display("FAIL cold_pmem got %0d events first addr %h want 1 read at 00001020",
                         ev_addr.size(), ev_addr.size() > 0 ? ev_addr[0] : 32'hx);
    end
    checks++;
    if (resp_count - r0 != 1) begin
      errors++; $display("FAIL cold_resp_pulses got %0d want 1", resp_count - r0);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int cyc;
    clear_events();
    do_req(1'b1, 32'h0000_1024, 4'b0011, 32'h1234_5678, rd, cyc);
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL wr_hit_latency got %0d want 2", cyc);
    end
    do_req(1'b0, 32'h0000_1024, 4'h0, 32'h0, rd, cyc);
    checks++;
    if (rd !== 32'hDEAD_5678 || cyc != 2) begin
      errors++; $display("FAIL wr_hit_readback got %h/%0d want dead5678/2", rd, cyc);
    end
    checks++;
    if (ev_addr.size() != 0) begin
      errors++; $display("FAIL wr_hit_pmem got %0d events want 0", ev_addr.size());
    end
  endtask

  task automatic test_dirty_conflict();
    logic [31:0] rd; int cyc;
    clear_events();
    do_req(1'b0, 32'h0000_2024, 4'h0, 32'h0, rd, cyc);
    checks++;
    if (ev_addr.size() != 2) begin
      errors++; $display("FAIL dirty_evcount got %0d want 2", ev_addr.size());
    end else begin
      checks++;
      if (ev_write[0] !== 1'b1 || ev_addr[0] !== 32'h0000_1020 ||
          ev_wdata[0][63:32] !== 32'hDEAD_5678) begin
        errors++; $display("FAIL dirty_wb got w=%b addr=%h word1=%h want 1/00001020/dead5678",
                           ev_write[0], ev_addr[0], ev_wdata[0][63:32]);
      end
      checks++;
      if (ev_write[1] !== 1'b0 || ev_addr[1] !== 32'h0000_2020) begin
        errors++; $display("FAIL dirty_fill got w=%b addr=%h want 0/00002020",
                           ev_write[1], ev_addr[1]);
      end
    end
    checks++;
    if (rd !== 32'h2222_1111 || cyc != 2 + 2 * LAT + 1) begin
      errors++; $display("FAIL dirty_rdata got %h/%0d want 22221111/%0d", rd, cyc, 2 + 2 * LAT + 1);
    end
  endtask

  task automatic test_clean_conflict();
    logic [31:0] rd; int cyc;
    clear_events();
    do_req(1'b0, 32'h0000_3024, 4'h0, 32'h0, rd, cyc);
    checks++;
    if (ev_addr.size() != 1 || ev_write[0] !== 1'b0 || ev_addr[0] !== 32'h0000_3020) begin
      errors++; $display("FAIL clean_pmem got %0d events want 1 read at 00003020", ev_addr.size());
    end
    checks++;
    if (rd !== 32'h3333_3333 || cyc != 2 + LAT + 1) begin
      errors++; $display("FAIL clean_rdata got %h/%0d want 33333333/%0d", rd, cyc, 2 + LAT + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int cyc; int r0;
    logic [31:0] exp_w [8] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                               32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007};
    do_req(1'b0, 32'h0000_3000, 4'h0, 32'h0, rd, cyc);  // warm the line
    clear_events(); r0 = resp_count;
    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, 32'h0000_3000 + 32'((i % 8) * 4), 4'h0, 32'h0, rd, cyc);
      checks++;
      if (rd !== exp_w[i % 8] || cyc != 2) begin
        errors++; $display("FAIL b2b_%0d got %h/%0d want %h/2", i, rd, cyc, exp_w[i % 8]);
      end
    end
    checks++;
    if (resp_count - r0 != 10 || ev_addr.size() != 0) begin
      errors++; $display("FAIL b2b_pulses got %0d resp %0d pmem want 10/0",
                         resp_count - r0, ev_addr.size());
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; int cyc;
    clear_events();
    mem_address = 32'h0000_4024; mem_read = 1'b1;
    @(posedge clk); #1;   // CHECK
    @(posedge clk); #1;   // ALLOCATE
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_4020) begin
      errors++; $display("FAIL abort_fill got rd=%b addr=%h want 1/00004020", pmem_read, pmem_address);
    end
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0 || pmem_address !== 0) begin
      errors++; $display("FAIL abort_drop got rd=%b wr=%b resp=%b addr=%h want idle",
                         pmem_read, pmem_write, mem_resp, pmem_address);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_events();
    do_req(1'b0, 32'h0000_4024, 4'h0, 32'h0, rd, cyc);
    checks++;
    if (cyc != 2 + LAT + 1 || ev_addr.size() != 1 || rd !== 32'h4444_1111) begin
      errors++; $display("FAIL abort_reread got %h/%0d cyc/%0d events want 44441111/%0d/1",
                         rd, cyc, ev_addr.size(), 2 + LAT + 1);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (overlap != 0 || unstable != 0) begin
      errors++; $display("FAIL pmem_protocol got overlap=%0d unstable=%0d want 0/0", overlap, unstable);
    end
  endtask

  initial begin
    mem[32'h0000_1020] = mk_line(32'h1020_0000, 32'hDEAD_BEEF);
    mem[32'h0000_2020] = mk_line(32'h2020_0000, 32'h2222_1111);
    mem[32'h0000_3020] = mk_line(32'h3020_0000, 32'h3333_3333);
    mem[32'h0000_3000] = mk_line(32'hA000_0000, 32'hA000_0001);
    mem[32'h0000_4020] = mk_line(32'h4020_0000, 32'h4444_1111);
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_conflict();
    test_clean_conflict();
    test_back_to_back();
    test_reset_abort();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_cache_responder.md
Name: dm_cache_responder

Overview:
- Direct-mapped, write-back, write-allocate cache that answers the CPU's 32-bit word memory interface: read/write, byte_enable, address, wdata in; resp, rdata out.
- Backs onto a 256-bit cacheline memory port, either the cacheline adapter or an arbiter port.
- Instantiated once per side: I-side with mem_write tied 0, D-side fully used.

Parameters:
- S_INDEX, 3, index bits; 2**S_INDEX sets.
- S_OFFSET, 5, offset bits; line = 32 bytes = 8 words = 256 bits; fixed.
- S_TAG, 32-S_OFFSET-S_INDEX, tag width; derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  4  byte lanes written on a write.
- mem_address  in  32  byte address; bits [1:0] ignored, [4:2] select word.
- mem_wdata  in  32  write data.
- mem_resp  out  1  one-cycle pulse completing the request.
- mem_rdata  out  32  read word; valid only while mem_resp=1.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_address  out  32  line-aligned address; [4:0]=0.
- pmem_wdata  out  256  writeback line.
- pmem_resp  in  1  one-cycle completion from memory.
- pmem_rdata  in  256  fill line; valid with pmem_resp.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; all valid and dirty bits=0. Outputs: mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0, pmem_wdata=0. Data and tag arrays are not cleared.
- Reset mid-miss aborts the pmem transaction: strobes drop next cycle and no line is installed.
- Address split: tag=[31:8], index=[7:5], word=[4:2] at default parameters.
- Hit condition: valid[index] && tag[index]==addr tag.
- FSM:
  - IDLE: if mem_read|mem_write, go to CHECK; else stay.
  - CHECK:
    - Hit: mem_resp=1 this cycle. Read drives mem_rdata = line word[addr[4:2]]. Write merges wdata bytes with byte_enable into that word and sets dirty at the edge. Next state IDLE.
    - Miss & dirty: go to WRITEBACK.
    - Miss & clean: go to ALLOCATE.
    - Request gone (protocol violation): go to IDLE, no resp.
  - WRITEBACK: pmem_write=1, pmem_address={stored tag,index,5'b0}, pmem_wdata=stored line. On pmem_resp, clear dirty and go to ALLOCATE.
  - ALLOCATE: pmem_read=1, pmem_address={addr[31:5],5'b0}. On pmem_resp, write pmem_rdata, set tag, valid=1, dirty=0, and go to CHECK (the hit path then completes the request).
- Latency:
  - Hit: resp in the 2nd cycle of the request.
  - Clean miss: 2 + fill cycles + 1.
  - Dirty miss: adds writeback cycles.
  - Back-to-back hits: one every 2 cycles; the CPU may raise a new request the cycle after resp.
- mem_read and mem_write both high is illegal; write takes priority.
- byte_enable=0000 on a write still hits/allocates, writes no bytes, and still sets dirty.
- pmem_read and pmem_write are never high together. Each stays high continuously until pmem_resp, with address and wdata stable throughout.
- Request inputs are sampled live in CHECK. The CPU must hold them stable; the cache does not latch them.

Decomposition:
- Package cache_types:
  - S_INDEX/S_OFFSET/S_TAG constants.
  - State enum {IDLE, CHECK, WRITEBACK, ALLOCATE}.
  - Line typedef logic[255:0].
- Sub-module dm_cache_array:
  - Flop-based tag, valid, dirty and data arrays.
  - Combinational read, synchronous write with per-byte 32-bit write-enable mask.
  - Reset clears valid and dirty.
- Top module holds the FSM, hit compare, word select and byte-merge logic.

Test Plan:
- Cold read 0x0000_1024 after reset. Required:
  - pmem_read=1 with pmem_address=0x0000_1020.
  - Memory returns a line whose word1=0xDEAD_BEEF.
  - mem_resp pulses once with mem_rdata=0xDEAD_BEEF, no pmem_write.
- Write hit, byte_enable=0011, wdata=0x1234_5678, to 0x0000_1024. Required:
  - Resp in the 2nd cycle.
  - A subsequent read returns 0xDEAD_5678.
  - No pmem activity.
- Conflict read 0x0000_2024 (same index 1, dirty line). Required:
  - pmem_write first, address 0x0000_1020, wdata word1=0xDEAD_5678.
  - Then pmem_read at 0x0000_2020.
  - Then resp.
- Clean conflict read 0x0000_3024 after the previous test. Required: no writeback; pmem_read only.
- rst=1 asserted during ALLOCATE, before pmem_resp. Required:
  - pmem_read=0 on the next cycle, state IDLE.
  - A re-read of the same address misses again.
- Ten back-to-back read hits to 0x0000_3000..0x0000_301C. Required: exactly one mem_resp pulse per request, every 2 cycles, correct words.
